// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   // Opcode field value that marks a halt instruction.
   localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

   // True when the opcode field of an instruction matches the halt opcode.
   function automatic logic is_halt(input logic [3:0] op_field,
                                    input logic [3:0] halt_op);
      return (op_field == halt_op);
   endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: clear beats load-target, load-target beats
// increment. Increment wraps naturally modulo 2^p_size.
module fetch_pc #(
   parameter int p_size = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              ld,
   input  logic [p_size-1:0] target,
   input  logic              inc,
   output logic [p_size-1:0] pc
);

   logic [p_size-1:0] pc_d;
   logic [p_size-1:0] pc_q;

   // Next-PC selection with fixed priority clear > load > increment.
   always_comb begin
      pc_d = pc_q;
      if (clr) begin
         pc_d = '0;
      end else if (ld) begin
         pc_d = target;
      end else if (inc) begin
         pc_d = pc_q + 1'b1;
      end
   end

   // PC state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, captures program memory data
// into the instruction register and offers it to decode.
//
// Handshake: ir/ir_valid form a valid/ready source. A transfer happens on
// any rising edge where ir_valid && ir_ready; ir must stay stable while
// ir_valid is high and ir_ready is low. ir_ready with ir_valid low is ignored.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int         p_size  = 6,
   parameter int         i_size  = 24,
   parameter logic [3:0] HALT_OP = HALT_OP_DEFAULT
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic              start,
   input  logic              stop,
   input  logic              branch_en,
   input  logic [p_size-1:0] branch_target,
   output logic [p_size-1:0] address,
   input  logic [i_size-1:0] instr,
   output logic [i_size-1:0] ir,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic              halted,
   output logic              busy
);

   fetch_state_t      state_d, state_q;
   logic [i_size-1:0] ir_d, ir_q;
   logic              ir_valid_d, ir_valid_q;
   logic              pc_clr, pc_ld, pc_inc;
   logic              transfer;
   logic              load;
   logic              halt_word;

   assign transfer  = ir_valid_q && ir_ready;
   assign load      = (state_q == FETCH) && (!ir_valid_q || ir_ready);
   assign halt_word = is_halt(instr[i_size-1 -: 4], HALT_OP);

   // Next state, IR and PC controls; stop outranks everything, and in
   // FETCH a branch outranks load, stall and halt detection.
   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      pc_clr     = 1'b0;
      pc_ld      = 1'b0;
      pc_inc     = 1'b0;
      if (stop) begin
         state_d    = IDLE;
         ir_valid_d = 1'b0;
         pc_clr     = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d    = FETCH;
                  ir_valid_d = 1'b0;
                  pc_clr     = 1'b1;
               end
            end
            FETCH: begin
               if (branch_en) begin
                  // Flush: whatever sat in ir is dropped (or was consumed).
                  ir_valid_d = 1'b0;
                  pc_ld      = 1'b1;
               end else if (load) begin
                  ir_d       = instr;
                  ir_valid_d = 1'b1;
                  if (halt_word) begin
                     state_d = HALTED;
                  end else begin
                     pc_inc = 1'b1;
                  end
               end
            end
            HALTED: begin
               if (start) begin
                  state_d    = FETCH;
                  ir_valid_d = 1'b0;
                  pc_clr     = 1'b1;
               end else if (transfer) begin
                  ir_valid_d = 1'b0;
               end
            end
            default: begin
               state_d    = IDLE;
               ir_valid_d = 1'b0;
               pc_clr     = 1'b1;
            end
         endcase
      end
   end

   // FSM state, instruction register and valid flag.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q    <= IDLE;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   fetch_pc #(
      .p_size (p_size)
   ) u_pc (
      .clk    (Clock),
      .rst_n  (nReset),
      .clr    (pc_clr),
      .ld     (pc_ld),
      .target (branch_target),
      .inc    (pc_inc),
      .pc     (address)
   );

   assign ir       = ir_q;
   assign ir_valid = ir_valid_q;
   assign halted   = (state_q == HALTED);
   assign busy     = (state_q == FETCH);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: halt run, stall, branch, branch-vs-halt,
// address wrap, async reset and stop.
module tb_fetch_ctrl;

   logic        Clock;
   logic        nReset;
   logic        start;
   logic        stop;
   logic        branch_en;
   logic [5:0]  branch_target;
   logic [5:0]  address;
   logic [23:0] instr;
   logic [23:0] ir;
   logic        ir_valid;
   logic        ir_ready;
   logic        halted;
   logic        busy;

   logic [23:0] prog [64];
   int          vectors;
   int          miscompares;

   fetch_ctrl #(
      .p_size  (6),
      .i_size  (24),
      .HALT_OP (4'hF)
   ) dut (
      .Clock         (Clock),
      .nReset        (nReset),
      .start         (start),
      .stop          (stop),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .address       (address),
      .instr         (instr),
      .ir            (ir),
      .ir_valid      (ir_valid),
      .ir_ready      (ir_ready),
      .halted        (halted),
      .busy          (busy)
   );

   // Combinational program memory.
   assign instr = prog[address];

   // Clock and reset
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Advance one rising edge and settle away from it.
   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [23:0] e_ir, input logic e_v,
                          input logic [5:0] e_addr, input logic e_busy, input logic e_halt);
      chk({tag, ".ir"},       {8'h0, ir},         {8'h0, e_ir});
      chk({tag, ".ir_valid"}, {31'h0, ir_valid},  {31'h0, e_v});
      chk({tag, ".address"},  {26'h0, address},   {26'h0, e_addr});
      chk({tag, ".busy"},     {31'h0, busy},      {31'h0, e_busy});
      chk({tag, ".halted"},   {31'h0, halted},    {31'h0, e_halt});
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      nReset        = 1'b0;
      start         = 1'b0;
      stop          = 1'b0;
      branch_en     = 1'b0;
      branch_target = '0;
      ir_ready      = 1'b0;
      for (int i = 0; i < 64; i++) prog[i] = 24'(i + 1);
      prog[4] = 24'hF00000;

      // Reset state
      step();
      step();
      chk_all("reset", 24'h0, 1'b0, 6'd0, 1'b0, 1'b0);
      nReset = 1'b1;
      step();
      chk_all("idle", 24'h0, 1'b0, 6'd0, 1'b0, 1'b0);

      // Straight run to halt
      ir_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk_all("run.start", 24'h0, 1'b0, 6'd0, 1'b1, 1'b0);
      step(); chk_all("run.w0", 24'h000001, 1'b1, 6'd1, 1'b1, 1'b0);
      step(); chk_all("run.w1", 24'h000002, 1'b1, 6'd2, 1'b1, 1'b0);
      step(); chk_all("run.w2", 24'h000003, 1'b1, 6'd3, 1'b1, 1'b0);
      step(); chk_all("run.w3", 24'h000004, 1'b1, 6'd4, 1'b1, 1'b0);
      step(); chk_all("run.halt", 24'hF00000, 1'b1, 6'd4, 1'b0, 1'b1);
      step(); chk_all("run.drain", 24'hF00000, 1'b0, 6'd4, 1'b0, 1'b1);
      step(); chk_all("run.held", 24'hF00000, 1'b0, 6'd4, 1'b0, 1'b1);

      // Stall for 3 cycles after the first load
      start = 1'b1;
      step();
      start = 1'b0;
      chk_all("stall.start", 24'hF00000, 1'b0, 6'd0, 1'b1, 1'b0);
      step(); chk_all("stall.w0", 24'h000001, 1'b1, 6'd1, 1'b1, 1'b0);
      ir_ready = 1'b0;
      step(); chk_all("stall.s1", 24'h000001, 1'b1, 6'd1, 1'b1, 1'b0);
      step(); chk_all("stall.s2", 24'h000001, 1'b1, 6'd1, 1'b1, 1'b0);
      step(); chk_all("stall.s3", 24'h000001, 1'b1, 6'd1, 1'b1, 1'b0);
      ir_ready = 1'b1;
      step(); chk_all("stall.w1", 24'h000002, 1'b1, 6'd2, 1'b1, 1'b0);
      step(); chk_all("stall.w2", 24'h000003, 1'b1, 6'd3, 1'b1, 1'b0);
      step(); chk_all("stall.w3", 24'h000004, 1'b1, 6'd4, 1'b1, 1'b0);
      step(); chk_all("stall.halt", 24'hF00000, 1'b1, 6'd4, 1'b0, 1'b1);

      // Branch to 20 while address is 2
      start = 1'b1;
      step();
      start = 1'b0;
      step(); chk_all("br.w0", 24'h000001, 1'b1, 6'd1, 1'b1, 1'b0);
      step(); chk_all("br.w1", 24'h000002, 1'b1, 6'd2, 1'b1, 1'b0);
      branch_en = 1'b1;
      branch_target = 6'd20;
      step();
      branch_en = 1'b0;
      chk_all("br.flush", 24'h000002, 1'b0, 6'd20, 1'b1, 1'b0);
      step(); chk_all("br.target", 24'h000015, 1'b1, 6'd21, 1'b1, 1'b0);

      // Branch while the halt word is being fetched: branch wins
      branch_en = 1'b1;
      branch_target = 6'd3;
      step();
      branch_en = 1'b0;
      chk_all("bh.to3", 24'h000015, 1'b0, 6'd3, 1'b1, 1'b0);
      step(); chk_all("bh.w3", 24'h000004, 1'b1, 6'd4, 1'b1, 1'b0);
      branch_en = 1'b1;
      branch_target = 6'd10;
      step();
      branch_en = 1'b0;
      chk_all("bh.win", 24'h000004, 1'b0, 6'd10, 1'b1, 1'b0);
      step(); chk_all("bh.w10", 24'h00000B, 1'b1, 6'd11, 1'b1, 1'b0);

      // Address wrap with no halt in the program
      prog[4] = 24'h000005;
      branch_en = 1'b1;
      branch_target = 6'd62;
      step();
      branch_en = 1'b0;
      chk_all("wrap.to62", 24'h00000B, 1'b0, 6'd62, 1'b1, 1'b0);
      step(); chk_all("wrap.w62", 24'h00003F, 1'b1, 6'd63, 1'b1, 1'b0);
      step(); chk_all("wrap.w63", 24'h000040, 1'b1, 6'd0, 1'b1, 1'b0);
      step(); chk_all("wrap.w0", 24'h000001, 1'b1, 6'd1, 1'b1, 1'b0);
      step(); chk_all("wrap.w1", 24'h000002, 1'b1, 6'd2, 1'b1, 1'b0);

      // Asynchronous reset mid-stream takes effect between edges
      #2;
      nReset = 1'b0;
      #1;
      chk_all("areset", 24'h0, 1'b0, 6'd0, 1'b0, 1'b0);
      step();
      nReset = 1'b1;
      step(); chk_all("areset.idle", 24'h0, 1'b0, 6'd0, 1'b0, 1'b0);

      // Restart, stall, then stop during the stall
      start = 1'b1;
      step();
      start = 1'b0;
      step(); chk_all("stop.w0", 24'h000001, 1'b1, 6'd1, 1'b1, 1'b0);
      ir_ready = 1'b0;
      step(); chk_all("stop.stall", 24'h000001, 1'b1, 6'd1, 1'b1, 1'b0);
      stop = 1'b1;
      start = 1'b1;
      branch_en = 1'b1;
      branch_target = 6'd30;
      step();
      stop = 1'b0;
      start = 1'b0;
      branch_en = 1'b0;
      chk_all("stop.idle", 24'h000001, 1'b0, 6'd0, 1'b0, 1'b0);
      step(); chk_all("stop.stays", 24'h000001, 1'b0, 6'd0, 1'b0, 1'b0);
      ir_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk_all("restart", 24'h000001, 1'b0, 6'd0, 1'b1, 1'b0);
      step(); chk_all("restart.w0", 24'h000001, 1'b1, 6'd1, 1'b1, 1'b0);
      step(); chk_all("restart.w1", 24'h000002, 1'b1, 6'd2, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
